// File: rtl/sobel_pkg.sv
// sobel_pkg: widths and pixel helpers shared by the Sobel edge pipeline
package sobel_pkg;
  localparam int PIX_W = 8;
  localparam int GRAD_W = 12;
  function automatic logic [PIX_W-1:0] luma(input logic [PIX_W-1:0] r, input logic [PIX_W-1:0] g, input logic [PIX_W-1:0] b);
    logic [9:0] s;
    s = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
    return s[9:2];
  endfunction
  function automatic logic [PIX_W-1:0] sat(input logic [GRAD_W-1:0] m);
    return (m > GRAD_W'(255)) ? 8'hff : m[PIX_W-1:0];
  endfunction
  function automatic logic signed [GRAD_W-1:0] ext(input logic [PIX_W-1:0] p);
    return $signed({{(GRAD_W-PIX_W){1'b0}}, p});
  endfunction
endpackage

// File: rtl/sobel_line_buffer.sv
// sobel_line_buffer: single-port line RAM; read is combinational so a write returns the old word
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter int DEPTH = 512,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             en,
  input  logic [AW-1:0]    addr,
  input  logic [PIX_W-1:0] din,
  output logic [PIX_W-1:0] dout
);
  logic [PIX_W-1:0] mem [DEPTH];
  assign dout = mem[addr];
  always_ff @(posedge clk) if (en) mem[addr] <= din;
endmodule

// File: rtl/sobel_edge_rgb.sv
// sobel_edge_rgb: streaming 3x3 Sobel |Gx|+|Gy| on RGB video, luma in, grey edge map out
// Input register, luma/position, window+gradients, magnitude/output: done trails input by 3 edges.
module sobel_edge_rgb
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH = 512,
  parameter int THRESHOLD = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] data_red_i,
  input  logic [PIX_W-1:0] data_green_i,
  input  logic [PIX_W-1:0] data_blue_i,
  input  logic             data_done_i,
  output logic [PIX_W-1:0] sobel_red_o,
  output logic [PIX_W-1:0] sobel_green_o,
  output logic [PIX_W-1:0] sobel_blue_o,
  output logic             sobel_done_o
);
  localparam int CW = $clog2(IMG_WIDTH);
  logic [PIX_W-1:0] r0, g0, b0, y1, q0, q1, edge_val;
  logic v0, v1, v2, e1, e2;
  logic [CW-1:0] col, col1;
  logic [1:0] row;
  logic [2:0][2:0][PIX_W-1:0] w, nw;
  logic signed [GRAD_W-1:0] gx, gy, gx_n, gy_n;
  logic [GRAD_W-1:0] ax, ay, mag;
  sobel_line_buffer #(.DEPTH(IMG_WIDTH)) u_lb0 (.clk(clk), .en(v1), .addr(col1), .din(y1), .dout(q0));
  sobel_line_buffer #(.DEPTH(IMG_WIDTH)) u_lb1 (.clk(clk), .en(v1), .addr(col1), .din(q0), .dout(q1));
  // Row 0 is the oldest line; column 2 is the newest pixel
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      nw[i][0] = w[i][1];
      nw[i][1] = w[i][2];
    end
    nw[0][2] = q1;
    nw[1][2] = q0;
    nw[2][2] = y1;
    gx_n = ext(nw[0][2]) + (ext(nw[1][2]) <<< 1) + ext(nw[2][2]) - ext(nw[0][0]) - (ext(nw[1][0]) <<< 1) - ext(nw[2][0]);
    gy_n = ext(nw[2][0]) + (ext(nw[2][1]) <<< 1) + ext(nw[2][2]) - ext(nw[0][0]) - (ext(nw[0][1]) <<< 1) - ext(nw[0][2]);
    ax = gx[GRAD_W-1] ? $unsigned(-gx) : $unsigned(gx);
    ay = gy[GRAD_W-1] ? $unsigned(-gy) : $unsigned(gy);
    mag = ax + ay;
    edge_val = (THRESHOLD == 0) ? sat(mag) : (mag >= GRAD_W'(THRESHOLD)) ? 8'hff : 8'h00;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      {r0, g0, b0, y1} <= '0;
      {v0, v1, v2, e1, e2} <= '0;
      col <= '0;
      col1 <= '0;
      row <= '0;
      w <= '0;
      gx <= '0;
      gy <= '0;
      sobel_red_o <= '0;
      sobel_done_o <= 1'b0;
    end else begin
      v0 <= data_done_i;
      if (data_done_i) {r0, g0, b0} <= {data_red_i, data_green_i, data_blue_i};
      v1 <= v0;
      if (v0) begin
        y1 <= luma(r0, g0, b0);
        col1 <= col;
        e1 <= (col >= CW'(2)) && (row == 2'd2);
        col <= (col == CW'(IMG_WIDTH - 1)) ? '0 : col + CW'(1);
        if (col == CW'(IMG_WIDTH - 1) && row != 2'd2) row <= row + 2'd1;
      end
      v2 <= v1;
      if (v1) begin
        w <= nw;
        gx <= gx_n;
        gy <= gy_n;
        e2 <= e1;
      end
      sobel_done_o <= v2;
      if (v2) sobel_red_o <= e2 ? edge_val : 8'h00;
    end
  end
  assign sobel_green_o = sobel_red_o;
  assign sobel_blue_o = sobel_red_o;
endmodule

// File: tb/tb_sobel_edge_rgb.sv
// tb_sobel_edge_rgb: directed frames with hand-derived edge maps, queue scoreboards per DUT
module tb_sobel_edge_rgb;
  typedef struct { logic [7:0] v; int t; } exp_t;
  logic clk = 0, rst = 0;
  logic [7:0] ra = 0, ga = 0, ba = 0, rb = 0, gb = 0, bb = 0;
  logic va = 0, vb = 0;
  logic [7:0] oa_r, oa_g, oa_b, ob_r, ob_g, ob_b;
  logic da, db;
  int cyc = 0, n_cmp = 0, n_bad = 0;
  exp_t qa[$], qb[$];
  sobel_edge_rgb #(.IMG_WIDTH(8), .THRESHOLD(0)) dut_a (
    .clk(clk), .rst(rst), .data_red_i(ra), .data_green_i(ga), .data_blue_i(ba), .data_done_i(va),
    .sobel_red_o(oa_r), .sobel_green_o(oa_g), .sobel_blue_o(oa_b), .sobel_done_o(da));
  sobel_edge_rgb #(.IMG_WIDTH(8), .THRESHOLD(100)) dut_b (
    .clk(clk), .rst(rst), .data_red_i(rb), .data_green_i(gb), .data_blue_i(bb), .data_done_i(vb),
    .sobel_red_o(ob_r), .sobel_green_o(ob_g), .sobel_blue_o(ob_b), .sobel_done_o(db));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (da) begin
    exp_t e;
    n_cmp++;
    if (qa.size() == 0) begin
      n_bad++;
      $display("FAIL a_unexpected: got output %0d at cycle %0d, required none", oa_r, cyc);
    end else begin
      e = qa.pop_front();
      if (oa_r !== e.v || oa_g !== e.v || oa_b !== e.v || cyc != e.t) begin
        n_bad++;
        $display("FAIL a_pixel: got rgb %0d,%0d,%0d at cycle %0d, required %0d at cycle %0d", oa_r, oa_g, oa_b, cyc, e.v, e.t);
      end
    end
  end
  always @(negedge clk) if (db) begin
    exp_t e;
    n_cmp++;
    if (qb.size() == 0) begin
      n_bad++;
      $display("FAIL b_unexpected: got output %0d at cycle %0d, required none", ob_r, cyc);
    end else begin
      e = qb.pop_front();
      if (ob_r !== e.v || ob_g !== e.v || ob_b !== e.v || cyc != e.t) begin
        n_bad++;
        $display("FAIL b_pixel: got rgb %0d,%0d,%0d at cycle %0d, required %0d at cycle %0d", ob_r, ob_g, ob_b, cyc, e.v, e.t);
      end
    end
  end
  task automatic check(input string name, input logic [7:0] got, input logic [7:0] req);
    n_cmp++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1; va = 0; vb = 0;
    @(negedge clk);
    check("rst_a_red", oa_r, 8'd0);
    check("rst_a_done", {7'd0, da}, 8'd0);
    check("rst_b_red", ob_r, 8'd0);
    check("rst_b_done", {7'd0, db}, 8'd0);
    rst = 0;
  endtask
  task automatic idle();
    @(negedge clk);
    va = 0; vb = 0;
  endtask
  task automatic drain();
    for (int i = 0; i < 20 && (qa.size() != 0 || qb.size() != 0); i++) @(negedge clk);
    n_cmp++;
    if (qa.size() != 0 || qb.size() != 0) begin
      n_bad++;
      $display("FAIL drain_timeout: got %0d/%0d pending, required 0/0", qa.size(), qb.size());
    end
  endtask
  // kind: 0 uniform white, 1 vertical black|white at col 4, 2 horizontal at row 2,
  // 3 coloured luma-20 left half on black, 4 luma-20 step, 5 luma-40 step
  task automatic frame(input int kind, input int npix, input bit gaps);
    for (int i = 0; i < npix; i++) begin
      int r, c;
      logic [23:0] rgb;
      logic [7:0] e;
      bit at_edge;
      r = i / 8; c = i % 8;
      at_edge = r >= 2 && (c == 4 || c == 5);
      case (kind)
        0: begin rgb = 24'hffffff; e = 0; end
        1: begin rgb = c >= 4 ? 24'hffffff : 24'h0; e = at_edge ? 8'd255 : 8'd0; end
        2: begin rgb = r >= 2 ? 24'hffffff : 24'h0; e = (c >= 2 && (r == 2 || r == 3)) ? 8'd255 : 8'd0; end
        3: begin rgb = c < 4 ? {8'd10, 8'd20, 8'd31} : 24'h0; e = at_edge ? 8'd80 : 8'd0; end
        4: begin rgb = c >= 4 ? 24'h141414 : 24'h0; e = 0; end
        default: begin rgb = c >= 4 ? 24'h282828 : 24'h0; e = at_edge ? 8'd255 : 8'd0; end
      endcase
      @(negedge clk);
      if (kind >= 4) begin
        {rb, gb, bb} = rgb; vb = 1; va = 0;
        qb.push_back('{e, cyc + 4});
      end else begin
        {ra, ga, ba} = rgb; va = 1; vb = 0;
        qa.push_back('{e, cyc + 4});
      end
      if (gaps) idle();
    end
    idle();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got no end of run, required finish");
    $fatal(1);
  end
  initial begin
    do_reset();
    frame(0, 32, 0);
    drain();
    do_reset();
    frame(1, 32, 0);
    drain();
    do_reset();
    frame(2, 48, 0);
    drain();
    do_reset();
    frame(1, 32, 1);
    drain();
    do_reset();
    frame(3, 24, 0);
    drain();
    do_reset();
    frame(1, 30, 0);
    drain();
    check("held_a_red", oa_r, 8'd255);
    do_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      {ra, ga, ba} = 24'hffffff; va = 1;
    end
    do_reset();
    repeat (6) @(negedge clk);
    frame(1, 32, 0);
    drain();
    do_reset();
    frame(4, 24, 0);
    drain();
    do_reset();
    frame(5, 24, 0);
    drain();
    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sobel_edge_rgb.md
Name: sobel_edge_rgb

Overview:
- Streaming Sobel edge detector for 24-bit RGB raster video, one pixel per valid cycle, with no backpressure.
- Converts each pixel to 8-bit luma and keeps two line buffers to form a 3x3 window.
- Computes |Gx|+|Gy| saturated to 8 bits and emits it on all three colour channels.
- Sits between the pixel source (e.g. the BMP/frame reader) and the frame writer; emits exactly one output pixel per input pixel.

Parameters:
- IMG_WIDTH, 512: pixels per line; sets line-buffer depth and column wrap. Must be ≥3.
- THRESHOLD, 0: 0 = output the raw magnitude; >0 = output 255 if magnitude ≥ THRESHOLD, else 0.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- data_red_i  in  8  input pixel red.
- data_green_i  in  8  input pixel green.
- data_blue_i  in  8  input pixel blue.
- data_done_i  in  1  input valid; pixel sampled on any rising edge where high.
- sobel_red_o  out  8  edge magnitude.
- sobel_green_o  out  8  same value as red.
- sobel_blue_o  out  8  same value as red.
- sobel_done_o  out  1  output valid.

Behaviour:
- Reset is synchronous, active-high, on clk. While rst is high:
  - all outputs = 0;
  - column counter = 0, row counter = 0;
  - window registers and pipeline valid bits cleared.
- Line-buffer RAM contents need not be cleared.
- Reset mid-frame discards all in-flight pixels; the next valid pixel is row 0, col 0.
- Luma: Y = (R + 2G + B) >> 2, computed in 10 bits and truncated to 8.
- Position tracking:
  - Column counter increments on each valid pixel and wraps IMG_WIDTH-1 → 0.
  - Row counter increments on wrap and saturates at 2; only "row ≥ 2" matters.
- Window:
  - A 3x3 luma window shifts left by one column on each valid pixel only.
  - Its newest column is {linebuf1[col], linebuf0[col], Y}.
  - Line buffer 0 then stores Y at col; line buffer 1 stores the old linebuf0[col].
  - Window row 0 is the oldest line.
- Kernels, signed 12-bit arithmetic, columns left to right:
  - Gx = (p02 + 2p12 + p22) − (p00 + 2p10 + p20).
  - Gy = (p20 + 2p21 + p22) − (p00 + 2p01 + p02).
  - mag = |Gx| + |Gy| (max 2040), saturated to 255.
- Border: if the current input's col < 2 or row < 2, the output for that pixel is 0. Such a window is incomplete or wraps across a line.
- Alignment: the output for input pixel (r,c) is the window centred on (r−1,c−1). No re-alignment or flush; the output count equals the input count.
- Pipeline, fixed latency 3 cycles, valid-tagged:
  - Stage 1: luma and position flags.
  - Stage 2: window shift and Gx/Gy.
  - Stage 3: abs, sum, saturate, threshold, output register.
- A pixel sampled at edge k produces sobel_done_o high with data after edge k+3.
- Gaps in data_done_i propagate as gaps in sobel_done_o. The window does not advance on invalid cycles.
- Back-to-back valid pixels are sustained indefinitely at 1 pixel/cycle.
- When sobel_done_o = 0, data outputs hold their last value.

Decomposition:
- Package sobel_pkg:
  - luma and kernel width constants (PIX_W=8, GRAD_W=12);
  - luma function;
  - saturate function.
- One natural sub-module: sobel_line_buffer. It is a single-port IMG_WIDTH×8 read-before-write RAM, instantiated twice.
- The window, kernel and output stages stay in the top module.

Test Plan:
- Reset then a uniform 255,255,255 frame, IMG_WIDTH=8, 4 rows → 32 outputs:
  - rows 0–1 and cols 0–1 of each row = 0;
  - interior = 0;
  - sobel_done_o is data_done_i delayed 3 cycles.
- Vertical edge, IMG_WIDTH=8: cols 0–3 = 0, cols 4–7 = 255 →
  - row ≥2 output at input col 4 and col 5 = 255;
  - input cols 2, 3, 6, 7 = 0.
- Horizontal edge: rows 0–1 = 0, rows 2+ = 255 (col ≥2) →
  - row-2 inputs output 255;
  - row-3 inputs output 255 (window spans the edge);
  - row 4+ output 0.
- Valid gaps: same vertical-edge frame with data_done_i low every other cycle → identical output values, gapped sobel_done_o.
- Reset asserted mid-row 3 for one cycle →
  - outputs and sobel_done_o = 0 the next cycle;
  - a restarted frame's first two rows output 0.
- THRESHOLD=100, single luma step of 20 (Gx=80) → output 0; step of 40 (Gx=160) → 255.
